// File: rtl/seq_divider_pkg.sv
// ---------------------------------------------------------------------------
// seq_divider_pkg : FSM state and op-code encodings for seq_divider  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none
`ifndef SEQ_DIVIDER_PKG_SV
`define SEQ_DIVIDER_PKG_SV

package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

`endif
`default_nettype wire

// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if : request/response handshake bundle for seq_divider  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface seq_divider_if #(
  parameter int WIDTH = 64
);
  import seq_divider_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op, dividend, divisor, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, dividend, divisor, out_ready,
    output in_ready, out_valid, result
  );

endinterface

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// ---------------------------------------------------------------------------
// div_step : one restoring-division step (shift, trial subtract, restore/keep)
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_step #(
  parameter int WIDTH = 64
) (
  input  wire logic [WIDTH-1:0] i_p,
  input  wire logic [WIDTH-1:0] i_q,
  input  wire logic [WIDTH-1:0] i_dvsr,
  output logic      [WIDTH-1:0] o_p,
  output logic      [WIDTH-1:0] o_q
);
  import seq_divider_pkg::*;

  logic [WIDTH:0] w_ps;
  logic [WIDTH:0] w_sum_lo;
  logic           w_carry;
  logic           w_borrow;

  assign w_ps = {i_p, i_q[WIDTH-1]};

  // WIDTH+1-bit subtract ps + ~{0,dvsr} + 1; the top slice adds ps[W] + 1 + carry_in,
  // whose carry-out collapses to ps[W] | carry_in.
  assign w_sum_lo = {1'b0, w_ps[WIDTH-1:0]} + {1'b0, ~i_dvsr} + {{WIDTH{1'b0}}, 1'b1};
  assign w_carry  = w_ps[WIDTH] | w_sum_lo[WIDTH];
  assign w_borrow = ~w_carry;

  assign o_p = w_borrow ? w_ps[WIDTH-1:0] : w_sum_lo[WIDTH-1:0];
  assign o_q = {i_q[WIDTH-2:0], ~w_borrow};

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider : multi-cycle restoring divider for DIV/DIVU/REM/REMU  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module seq_divider #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  wire logic     clk,
  input  wire logic     reset,
  seq_divider_if.slave  bus
);
  import seq_divider_pkg::*;

  localparam logic [WIDTH-1:0] C_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] C_ONES    = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_rem;

  logic             w_accept;
  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div0;
  logic             w_ovf;
  logic             w_special;
  logic [WIDTH-1:0] w_special_res;
  logic [WIDTH-1:0] w_step_p;
  logic [WIDTH-1:0] w_step_q;
  logic             w_last;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);
  assign w_signed = op_is_signed(bus.op);
  assign w_sa     = w_signed & bus.dividend[WIDTH-1];
  assign w_sb     = w_signed & bus.divisor[WIDTH-1];
  assign w_abs_a  = w_sa ? (~bus.dividend + 1'b1) : bus.dividend;
  assign w_abs_b  = w_sb ? (~bus.divisor + 1'b1) : bus.divisor;

  // Zero divisor and signed overflow bypass CALC and are resolved on the accept edge.
  assign w_div0    = (bus.divisor == '0);
  assign w_ovf     = w_signed && (bus.dividend == C_MIN_NEG) && (bus.divisor == C_ONES);
  assign w_special = w_div0 || w_ovf;
  always_comb begin
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = op_is_rem(bus.op) ? bus.dividend : C_ONES;
    end else begin
      w_special_res = op_is_rem(bus.op) ? '0 : bus.dividend;
    end
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_p    (r_p),
    .i_q    (r_q),
    .i_dvsr (r_dvsr),
    .o_p    (w_step_p),
    .o_q    (w_step_q)
  );

  assign w_last  = (r_cnt == C_LAST);
  assign w_q_fix = r_neg_q ? (~r_q + 1'b1) : r_q;
  assign w_r_fix = r_neg_r ? (~r_p + 1'b1) : r_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_special ? ST_DONE : ST_CALC;
      ST_CALC: if (w_last) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p      <= '0;
      r_q      <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rem   <= op_is_rem(bus.op);
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_q     <= w_abs_a;
            r_dvsr  <= w_abs_b;
            r_p     <= '0;
            r_cnt   <= '0;
            if (w_special) begin
              r_result <= w_special_res;
            end
          end
        end
        ST_CALC: begin
          r_p   <= w_step_p;
          r_q   <= w_step_q;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FIX: begin
          r_result <= r_rem ? w_r_fix : w_q_fix;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider : directed self-checking bench for seq_divider  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W), .CNT_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic send(input string tag, input logic [1:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    check({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = 64'hDEAD_BEEF_0BAD_F00D;
    bus.divisor  = 64'h0000_0000_0000_0003;
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) check({tag, "_timeout"}, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
    int lat;
    send(tag, op, a, b);
    wait_valid(tag, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check(tag, bus.result, exp);
    take();
    check({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = OP_DIV;
    bus.dividend  = '0;
    bus.divisor   = '0;
    reset         = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result",    bus.result,         64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Normal ops: 65 edges after the accept edge (66 counting it)
    run("divu",  OP_DIVU, 64'd100, 64'd7, 64'd14, 65);
    run("remu",  OP_REMU, 64'd100, 64'd7, 64'd2,  65);
    run("div_n", OP_DIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    run("rem_n", OP_REM,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run("rem_d", OP_REM,  64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65);
    run("div_d", OP_DIV,  64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    run("div_t", OP_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("rem_t", OP_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("divu_big", OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000,
        64'h0000_0000_FFFF_FFFF, 65);

    // Divide by zero and signed overflow
    run("divu_z", OP_DIVU, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("remu_z", OP_REMU, 64'h1234, 64'd0, 64'h1234, 0);
    run("rem_z",  OP_REM,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 0);
    run("div_ov", OP_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 0);
    run("rem_ov", OP_REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);

    // Input activity mid-CALC, then back-pressure in DONE
    send("hold", OP_DIVU, 64'd1000, 64'd10);
    repeat (20) begin @(posedge clk); #1; end
    check("calc_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    bus.op       = OP_DIV;
    bus.dividend = 64'd5;
    bus.divisor  = 64'd0;
    repeat (5) begin @(posedge clk); #1; end
    check("calc_in_ready2", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    wait_valid("hold", lat);
    check("hold_res", bus.result, 64'd100);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_stable", bus.result, 64'd100);
      check("hold_valid",  64'(bus.out_valid), 64'd1);
      check("hold_ready",  64'(bus.in_ready),  64'd0);
    end
    take();
    check("hold_idle", 64'(bus.in_ready), 64'd1);

    // Abort at step 30 via asynchronous reset
    send("abort", OP_DIVU, 64'd12345, 64'd3);
    repeat (30) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_ready", 64'(bus.in_ready),  64'd1);
    @(posedge clk); #1;
    check("abort_result", bus.result, 64'd0);
    reset = 1'b0;
    run("divu_ones", OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
